cart_loader: RTL

CART_LOADER -- requirements
Module: cart_loader

---
 rtl/rx78_pkg.sv | 27 ++
 rtl/hold_timer.sv | 26 ++
 rtl/cart_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rx78_pkg.sv
// Shared types and constants for the cartridge image loader.
// CART_LOADER_PAD_EN adds the PAD state that sweeps the image up to the next 8 KiB bank end.
package rx78_pkg;

  localparam int unsigned ADDR_W = 25;
  localparam logic [ADDR_W-1:0] BANK_SIZE = 25'h2000;
  localparam logic [7:0] PAD_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_FIN
`ifdef CART_LOADER_PAD_EN
    ,
    ST_PAD
`endif
  } state_t;

  // Last address the pad sweep reaches: end of the bank holding the last byte,
  // never below the end of bank 0. BANK_SIZE must be a power of two.
  function automatic logic [ADDR_W-1:0] pad_last(input logic [ADDR_W-1:0] len);
    if (len == '0) return BANK_SIZE - 1'b1;
    return (len - 1'b1) | (BANK_SIZE - 1'b1);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Down-counter that paces how long each byte stays on the upload bus.
module hold_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic       expired
);

  logic [7:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/cart_loader.sv
// Streams a cartridge image from a byte source onto the upload bus, holding each byte HOLD_CYCLES clocks.
// Define CART_LOADER_PAD_EN to pad with 8'hFF up to the end of the 8 KiB bank (at least 0..1FFF).
module cart_loader
  import rx78_pkg::*;
#(
  parameter int unsigned       HOLD_CYCLES = 4,
  parameter logic [ADDR_W-1:0] MAX_LEN     = 25'h8000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        index,
  input  logic [ADDR_W-1:0] length,
  input  logic              src_valid,
  input  logic [7:0]        src_data,
  output logic              src_ready,
  output logic              upload,
  output logic [7:0]        upload_index,
  output logic [ADDR_W-1:0] upload_addr,
  output logic [7:0]        upload_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] offset_q;   // bytes accepted so far; next byte's offset
  logic              len_bad;
  logic              timer_load;
  logic              timer_expired;
`ifdef CART_LOADER_PAD_EN
  logic [ADDR_W-1:0] pad_end_q;
`endif

  assign len_bad   = (length > MAX_LEN);
  assign src_ready = (state == ST_FETCH);
  assign busy      = (state != ST_IDLE) && (state != ST_FIN);
  assign done      = (state == ST_FIN);

  hold_timer u_hold_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (HOLD_RELOAD),
    .expired    (timer_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (len_bad) begin
            state_nxt = ST_FIN;
          end else if (length == '0) begin
`ifdef CART_LOADER_PAD_EN
            state_nxt  = ST_PAD;
            timer_load = 1'b1;
`else
            state_nxt  = ST_FIN;
`endif
          end else begin
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (src_valid) begin
          state_nxt  = ST_HOLD;
          timer_load = 1'b1;
        end
      end
      ST_HOLD: begin
        if (timer_expired) begin
          if (offset_q != len_q) begin
            state_nxt = ST_FETCH;
          end else begin
`ifdef CART_LOADER_PAD_EN
            if (upload_addr == pad_end_q) begin
              state_nxt = ST_FIN;
            end else begin
              state_nxt  = ST_PAD;
              timer_load = 1'b1;
            end
`else
            state_nxt = ST_FIN;
`endif
          end
        end
      end
`ifdef CART_LOADER_PAD_EN
      ST_PAD: begin
        if (timer_expired) begin
          if (upload_addr == pad_end_q) state_nxt = ST_FIN;
          else                          timer_load = 1'b1;
        end
      end
`endif
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus registers: addr/data change only when a new byte is presented, so
  // they naturally hold through FETCH stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upload       <= 1'b0;
      upload_index <= '0;
      upload_addr  <= '0;
      upload_data  <= '0;
      err          <= 1'b0;
      len_q        <= '0;
      offset_q     <= '0;
`ifdef CART_LOADER_PAD_EN
      pad_end_q    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            upload_index <= index;
            len_q        <= length;
            offset_q     <= '0;
            upload_addr  <= '0;
            err          <= len_bad;
`ifdef CART_LOADER_PAD_EN
            pad_end_q    <= pad_last(length);
            if (!len_bad && length == '0) begin
              upload      <= 1'b1;
              upload_data <= PAD_BYTE;
            end
`endif
          end
        end
        ST_FETCH: begin
          if (src_valid) begin
            upload      <= 1'b1;
            upload_data <= src_data;
            upload_addr <= offset_q;
            offset_q    <= offset_q + 1'b1;
          end
        end
`ifdef CART_LOADER_PAD_EN
        ST_HOLD, ST_PAD: begin
          if (timer_load) begin
            upload_addr <= upload_addr + 1'b1;
            upload_data <= PAD_BYTE;
          end
        end
`endif
        default: ;
      endcase
      if (state_nxt == ST_FIN) upload <= 1'b0;
    end
  end

endmodule
